// File: rtl/rv_mem_arbiter_if.sv
// rv_mem_arbiter_if: I/D requester ports plus shared memory port of the arbiter
// Ports: i_* fetch request/grant/response, d_* data request/grant/response,
//        mem_* shared single-port memory request/grant/response.
// slave = arbiter view, master = requester/memory side (core wrapper or bench).
interface rv_mem_arbiter_if #(parameter int XLEN = 32);
    logic              i_req_i;
    logic [XLEN-1:0]   i_addr_i;
    logic              i_gnt_o;
    logic              i_rvalid_o;
    logic [XLEN-1:0]   i_rdata_o;
    logic              d_req_i;
    logic              d_we_i;
    logic [XLEN/8-1:0] d_be_i;
    logic [XLEN-1:0]   d_addr_i;
    logic [XLEN-1:0]   d_wdata_i;
    logic              d_gnt_o;
    logic              d_rvalid_o;
    logic [XLEN-1:0]   d_rdata_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [XLEN/8-1:0] mem_be_o;
    logic [XLEN-1:0]   mem_addr_o;
    logic [XLEN-1:0]   mem_wdata_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [XLEN-1:0]   mem_rdata_i;
    modport slave (
        input  i_req_i, i_addr_i, d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
               mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output i_gnt_o, i_rvalid_o, i_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
               mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );
    modport master (
        output i_req_i, i_addr_i, d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
               mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  i_gnt_o, i_rvalid_o, i_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
               mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: shares one memory bus between fetch (I) and data (D) ports
// Ports: clk_i clock, arst_i async active-high reset, bus slave modport carrying
//        the I/D requester handshakes and the shared memory request/response.
// One outstanding transaction; D has priority, bounded by a streak guard for I.
module rv_mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int MAX_D_STREAK = 4
) (
    input logic              clk_i,
    input logic              arst_i,
    rv_mem_arbiter_if.slave  bus
);
    localparam int SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;
    state_t        state, state_nx;
    logic          owner_d, owner_nx, cur_d, forced, req_any, fire;
    logic [SW-1:0] streak, streak_nx;
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state   <= IDLE;
            owner_d <= 1'b0;
            streak  <= '0;
        end else begin
            state   <= state_nx;
            owner_d <= owner_nx;
            streak  <= streak_nx;
        end
    end
    always_comb begin
        forced  = (MAX_D_STREAK != 0) && (streak == SW'(MAX_D_STREAK)) && bus.i_req_i;
        // In IDLE the select is live; afterwards the latched owner drives the bus.
        cur_d   = (state == IDLE) ? (bus.d_req_i && !forced) : owner_d;
        req_any = (state == IDLE) ? (bus.i_req_i || bus.d_req_i) : (state == ADDR);
        fire    = req_any && bus.mem_gnt_i;
        bus.mem_req_o   = req_any;
        bus.mem_we_o    = req_any && cur_d && bus.d_we_i;
        bus.mem_be_o    = !req_any ? '0 : cur_d ? bus.d_be_i : {(XLEN/8){1'b1}};
        bus.mem_addr_o  = !req_any ? '0 : cur_d ? bus.d_addr_i : bus.i_addr_i;
        bus.mem_wdata_o = (req_any && cur_d) ? bus.d_wdata_i : '0;
        bus.i_gnt_o     = fire && !cur_d;
        bus.d_gnt_o     = fire && cur_d;
        bus.i_rvalid_o  = (state == RESP) && bus.mem_rvalid_i && !owner_d;
        bus.d_rvalid_o  = (state == RESP) && bus.mem_rvalid_i && owner_d;
        bus.i_rdata_o   = bus.mem_rdata_i;
        bus.d_rdata_o   = bus.mem_rdata_i;
        owner_nx  = (state == IDLE && req_any) ? cur_d : owner_d;
        streak_nx = (fire && cur_d && bus.i_req_i) ?
                        ((streak == SW'(MAX_D_STREAK)) ? streak : streak + SW'(1)) :
                    fire ? '0 : streak;
        state_nx  = state;
        case (state)
            IDLE:    state_nx = req_any ? (bus.mem_gnt_i ? RESP : ADDR) : IDLE;
            ADDR:    state_nx = bus.mem_gnt_i ? RESP : ADDR;
            RESP:    state_nx = bus.mem_rvalid_i ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rv_mem_arbiter.sv
// tb_rv_mem_arbiter: self-checking bench for rv_mem_arbiter (vector table + grant/response scoreboard)
module tb_rv_mem_arbiter;
    localparam int XLEN = 32;
    logic clk_i = 1'b0;
    logic arst_i;
    always #5 clk_i = ~clk_i;
    rv_mem_arbiter_if #(.XLEN(XLEN)) bus ();
    rv_mem_arbiter_if #(.XLEN(XLEN)) bus0 ();
    rv_mem_arbiter #(.XLEN(XLEN), .MAX_D_STREAK(4)) dut (.clk_i(clk_i), .arst_i(arst_i), .bus(bus));
    rv_mem_arbiter #(.XLEN(XLEN), .MAX_D_STREAK(0)) dut0 (.clk_i(clk_i), .arst_i(arst_i), .bus(bus0));
    assign bus0.i_req_i      = bus.i_req_i;
    assign bus0.i_addr_i     = bus.i_addr_i;
    assign bus0.d_req_i      = bus.d_req_i;
    assign bus0.d_we_i       = bus.d_we_i;
    assign bus0.d_be_i       = bus.d_be_i;
    assign bus0.d_addr_i     = bus.d_addr_i;
    assign bus0.d_wdata_i    = bus.d_wdata_i;
    assign bus0.mem_gnt_i    = bus.mem_gnt_i;
    assign bus0.mem_rvalid_i = bus.mem_rvalid_i;
    assign bus0.mem_rdata_i  = bus.mem_rdata_i;
    typedef struct {
        logic        i_req, d_req, gnt;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_ig, exp_dg;
    } vec_t;
    typedef struct {
        logic        d;
        logic [31:0] rdata;
    } rsp_t;
    vec_t vecs[7];
    logic gq[$];
    rsp_t rq[$];
    int   n_chk = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;
    logic i_pend, d_pend;
    int   d0_i, d0_d;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic idle_inputs();
        bus.i_req_i = 0; bus.i_addr_i = '0;
        bus.d_req_i = 0; bus.d_we_i = 0; bus.d_be_i = '0; bus.d_addr_i = '0; bus.d_wdata_i = '0;
        bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = '0;
    endtask
    task automatic do_reset();
        arst_i = 1'b1;
        idle_inputs();
        @(posedge clk_i); #1;
        arst_i = 1'b0;
    endtask
    task automatic step();
        @(posedge clk_i); #1;
    endtask
    // Requester rule: once raised, req must stay up until its gnt.
    always @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            i_pend <= 1'b0;
            d_pend <= 1'b0;
        end else begin
            if (i_pend && !bus.i_req_i) begin n_fail++; $error("FAIL req_hold_i dropped before gnt"); end
            if (d_pend && !bus.d_req_i) begin n_fail++; $error("FAIL req_hold_d dropped before gnt"); end
            i_pend <= bus.i_req_i && !bus.i_gnt_o;
            d_pend <= bus.d_req_i && !bus.d_gnt_o;
        end
    end
    // Scoreboard: each grant / response pops the next expected entry.
    always @(negedge clk_i) begin
        if (mon_en && !arst_i) begin
            if (bus.i_gnt_o || bus.d_gnt_o) begin
                check("gnt_rvalid_excl", {63'd0, (bus.i_gnt_o && bus.i_rvalid_o) || (bus.d_gnt_o && bus.d_rvalid_o)}, 64'd0);
                if (gq.size() == 0) check("gnt_unexpected", 64'd1, 64'd0);
                else check("gnt_port", {63'd0, bus.d_gnt_o}, {63'd0, gq.pop_front()});
            end
            if (bus.i_rvalid_o || bus.d_rvalid_o) begin
                if (rq.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
                else begin
                    rsp_t e;
                    e = rq.pop_front();
                    check("rsp_port", {63'd0, bus.d_rvalid_o}, {63'd0, e.d});
                    check("rsp_data", {32'd0, bus.d_rvalid_o ? bus.d_rdata_o : bus.i_rdata_o}, {32'd0, e.rdata});
                end
            end
        end
    end
    initial begin
        vecs[0] = '{0, 0, 0, 0, 32'h0,  0, 0};
        vecs[1] = '{1, 0, 0, 1, 32'hA0, 0, 0};
        vecs[2] = '{1, 0, 1, 1, 32'hA0, 1, 0};
        vecs[3] = '{0, 1, 0, 1, 32'hB0, 0, 0};
        vecs[4] = '{0, 1, 1, 1, 32'hB0, 0, 1};
        vecs[5] = '{1, 1, 1, 1, 32'hB0, 0, 1};
        vecs[6] = '{1, 1, 0, 1, 32'hB0, 0, 0};
        arst_i = 1'b1;
        idle_inputs();
        #1;
        check("rst_gnt",    {62'd0, bus.i_gnt_o, bus.d_gnt_o}, 64'd0);
        check("rst_rvalid", {62'd0, bus.i_rvalid_o, bus.d_rvalid_o}, 64'd0);
        check("rst_mem",    {bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o}, 64'd0);
        check("rst_wdata",  {32'd0, bus.mem_wdata_o}, 64'd0);
        @(posedge clk_i); #1;
        arst_i = 1'b0;
        // IDLE select table
        for (int k = 0; k < 7; k++) begin
            do_reset();
            bus.i_req_i = vecs[k].i_req; bus.i_addr_i = 32'hA0;
            bus.d_req_i = vecs[k].d_req; bus.d_addr_i = 32'hB0; bus.d_be_i = 4'hF;
            bus.mem_gnt_i = vecs[k].gnt;
            @(negedge clk_i);
            check($sformatf("vec%0d_req", k),  {63'd0, bus.mem_req_o}, {63'd0, vecs[k].exp_req});
            check($sformatf("vec%0d_addr", k), {32'd0, bus.mem_addr_o}, {32'd0, vecs[k].exp_addr});
            check($sformatf("vec%0d_ignt", k), {63'd0, bus.i_gnt_o}, {63'd0, vecs[k].exp_ig});
            check($sformatf("vec%0d_dgnt", k), {63'd0, bus.d_gnt_o}, {63'd0, vecs[k].exp_dg});
        end
        // 1: I alone, immediate grant
        do_reset();
        bus.i_req_i = 1; bus.i_addr_i = 32'h000100dc; bus.mem_gnt_i = 1;
        @(negedge clk_i);
        check("t1_addr", {32'd0, bus.mem_addr_o}, 64'h100dc);
        check("t1_ignt", {63'd0, bus.i_gnt_o}, 64'd1);
        check("t1_we",   {63'd0, bus.mem_we_o}, 64'd0);
        step();
        bus.i_req_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h00000513;
        @(negedge clk_i);
        check("t1_irvalid", {63'd0, bus.i_rvalid_o}, 64'd1);
        check("t1_irdata",  {32'd0, bus.i_rdata_o}, 64'h513);
        check("t1_drvalid", {63'd0, bus.d_rvalid_o}, 64'd0);
        check("t1_ignt_r",  {63'd0, bus.i_gnt_o}, 64'd0);
        step();
        // 2: simultaneous I and D, D first
        do_reset();
        mon_en = 1;
        gq.push_back(1); gq.push_back(0);
        rq.push_back('{1'b1, 32'h11}); rq.push_back('{1'b0, 32'h11});
        bus.i_req_i = 1; bus.i_addr_i = 32'h1000;
        bus.d_req_i = 1; bus.d_addr_i = 32'h2000; bus.d_be_i = 4'hF;
        bus.mem_gnt_i = 1; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h11;
        @(negedge clk_i);
        check("t2_daddr", {32'd0, bus.mem_addr_o}, 64'h2000);
        check("t2_ignt0", {63'd0, bus.i_gnt_o}, 64'd0);
        step();
        bus.d_req_i = 0;
        @(negedge clk_i);
        check("t2_ignt1", {63'd0, bus.i_gnt_o}, 64'd0);
        step();
        @(negedge clk_i);
        check("t2_iaddr", {32'd0, bus.mem_addr_o}, 64'h1000);
        check("t2_ignt2", {63'd0, bus.i_gnt_o}, 64'd1);
        step();
        bus.i_req_i = 0;
        @(negedge clk_i);
        step();
        check("t2_gq_empty", gq.size(), 64'd0);
        check("t2_rq_empty", rq.size(), 64'd0);
        // 3: continuous contention, streak guard vs strict priority
        do_reset();
        begin
            int s;
            s = 0;
            for (int k = 0; k < 10; k++) begin
                if (s == 4) begin gq.push_back(0); rq.push_back('{1'b0, 32'h77}); s = 0; end
                else begin gq.push_back(1); rq.push_back('{1'b1, 32'h77}); s++; end
            end
        end
        d0_i = 0; d0_d = 0;
        bus.i_req_i = 1; bus.i_addr_i = 32'h1100;
        bus.d_req_i = 1; bus.d_addr_i = 32'h2200; bus.d_be_i = 4'hF;
        bus.mem_gnt_i = 1; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h77;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            if (bus0.i_gnt_o) d0_i++;
            if (bus0.d_gnt_o) d0_d++;
            step();
        end
        check("t3_gq_empty", gq.size(), 64'd0);
        check("t3_rq_empty", rq.size(), 64'd0);
        check("t3_strict_i", d0_i, 64'd0);
        check("t3_strict_d", d0_d, 64'd10);
        // 4: I waits in ADDR, D must not steal the bus
        do_reset();
        gq.push_back(0); gq.push_back(1);
        rq.push_back('{1'b0, 32'h44}); rq.push_back('{1'b1, 32'h44});
        bus.i_req_i = 1; bus.i_addr_i = 32'h400;
        @(negedge clk_i);
        check("t4_addr0", {32'd0, bus.mem_addr_o}, 64'h400);
        step();
        bus.d_req_i = 1; bus.d_addr_i = 32'h500; bus.d_be_i = 4'hF;
        for (int c = 1; c < 3; c++) begin
            @(negedge clk_i);
            check($sformatf("t4_addr%0d", c), {32'd0, bus.mem_addr_o}, 64'h400);
            check($sformatf("t4_dgnt%0d", c), {62'd0, bus.mem_req_o, bus.d_gnt_o}, 64'd2);
            step();
        end
        bus.mem_gnt_i = 1;
        @(negedge clk_i);
        check("t4_ignt3", {62'd0, bus.i_gnt_o, bus.d_gnt_o}, 64'd2);
        step();
        bus.i_req_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h44;
        @(negedge clk_i);
        check("t4_dgnt4", {63'd0, bus.d_gnt_o}, 64'd0);
        step();
        @(negedge clk_i);
        check("t4_daddr", {32'd0, bus.mem_addr_o}, 64'h500);
        step();
        bus.d_req_i = 0;
        @(negedge clk_i);
        step();
        check("t4_gq_empty", gq.size(), 64'd0);
        check("t4_rq_empty", rq.size(), 64'd0);
        mon_en = 0;
        // 5: store
        do_reset();
        bus.d_req_i = 1; bus.d_we_i = 1; bus.d_be_i = 4'b0011;
        bus.d_addr_i = 32'h3000; bus.d_wdata_i = 32'hdeadbeef; bus.mem_gnt_i = 1;
        @(negedge clk_i);
        check("t5_we",    {63'd0, bus.mem_we_o}, 64'd1);
        check("t5_be",    {60'd0, bus.mem_be_o}, 64'h3);
        check("t5_addr",  {32'd0, bus.mem_addr_o}, 64'h3000);
        check("t5_wdata", {32'd0, bus.mem_wdata_o}, 64'hdeadbeef);
        check("t5_dgnt",  {63'd0, bus.d_gnt_o}, 64'd1);
        step();
        bus.d_req_i = 0; bus.mem_rvalid_i = 1;
        @(negedge clk_i);
        check("t5_rvalid", {62'd0, bus.i_rvalid_o, bus.d_rvalid_o}, 64'd1);
        check("t5_idle_bus", {bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o}, 64'd0);
        step();
        // 6: reset mid-RESP drops the transaction
        do_reset();
        bus.i_req_i = 1; bus.i_addr_i = 32'h100; bus.mem_gnt_i = 1;
        step();
        bus.i_req_i = 0; bus.mem_gnt_i = 0;
        #2;
        arst_i = 1'b1;
        #1;
        check("t6_rst_out", {58'd0, bus.i_gnt_o, bus.d_gnt_o, bus.i_rvalid_o, bus.d_rvalid_o, bus.mem_req_o, bus.mem_we_o}, 64'd0);
        check("t6_rst_addr", {32'd0, bus.mem_addr_o}, 64'd0);
        @(posedge clk_i); #1;
        arst_i = 1'b0;
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h99;
        @(negedge clk_i);
        check("t6_stale", {62'd0, bus.i_rvalid_o, bus.d_rvalid_o}, 64'd0);
        step();
        bus.mem_rvalid_i = 0; bus.i_req_i = 1; bus.i_addr_i = 32'h104; bus.mem_gnt_i = 1;
        @(negedge clk_i);
        check("t6_ignt", {63'd0, bus.i_gnt_o}, 64'd1);
        check("t6_addr", {32'd0, bus.mem_addr_o}, 64'h104);
        step();
        bus.i_req_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h13;
        @(negedge clk_i);
        check("t6_irvalid", {63'd0, bus.i_rvalid_o}, 64'd1);
        check("t6_irdata", {32'd0, bus.i_rdata_o}, 64'h13);
        step();
        idle_inputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
